// File: rtl/axi_mem_responder.sv
// axi_mem_responder
//   AXI4 slave memory model acting as the responder for a core's master port.
//   Serves INCR read and write bursts from an internal 64-bit-word array with
//   one outstanding transaction per channel. After every clean write burst an
//   ACE MakeInvalid snoop is issued on AC before the B response.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   s_axi_aw*         write address channel (awready out)
//   s_axi_w*          write data channel (wready out)
//   s_axi_b*          write response channel (bready in)
//   s_axi_ar*         read address channel (arready out)
//   s_axi_r*          read data channel (rready in)
//   s_axi_ac*         snoop request channel (acready in)
//
// Read FSM
//   state   | meaning
//   R_IDLE  | arready high, waiting for an AR handshake
//   R_WAIT  | counting READ_LATENCY idle cycles; the last one loads beat 0
//   R_BURST | rvalid high with a registered beat; advances on each R handshake
//
// Write FSM
//   state   | meaning
//   W_IDLE  | awready high, waiting for an AW handshake
//   W_DATA  | wready high, accepting beats until wlast or beat number len
//   W_SNOOP | acvalid high with MakeInvalid for the burst's 64-byte line
//   W_RESP  | bvalid high with the worst error seen over the burst
module axi_mem_responder #(
  parameter int                    ID_WIDTH     = 13,
  parameter int                    ADDR_WIDTH   = 64,
  parameter int                    DATA_WIDTH   = 64,
  parameter int                    MEM_WORDS    = 4096,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0,
  parameter int                    READ_LATENCY = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  input  logic                    s_axi_rready,
  output logic                    s_axi_acvalid,
  output logic [ADDR_WIDTH-1:0]   s_axi_acaddr,
  output logic [3:0]              s_axi_acsnoop,
  input  logic                    s_axi_acready
);

  localparam int                    IDX_W   = $clog2(MEM_WORDS);
  localparam logic [ADDR_WIDTH-1:0] DEPTH   = ADDR_WIDTH'(MEM_WORDS);
  localparam logic [7:0]            RL_LAST = 8'(READ_LATENCY - 1);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_BURST} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_SNOOP, W_RESP} w_state_t;

  // Encodings are ordered so that the numerically larger code is the worse error.
  function automatic logic [1:0] worse(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [DATA_WIDTH-1:0] mem [MEM_WORDS];

  // Holds both address channels off for one cycle after reset release.
  logic ready_en_q;

  r_state_t              r_state_q, r_state_d;
  logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
  logic [ADDR_WIDTH-1:0] r_addr_q, r_addr_d;
  logic [7:0]            r_len_q, r_len_d, r_cnt_q, r_cnt_d, r_wait_q, r_wait_d;
  logic                  r_fmt_err_q, r_fmt_err_d;
  logic                  r_valid_q, r_valid_d, r_last_q, r_last_d;
  logic [DATA_WIDTH-1:0] r_data_q, r_data_d;
  logic [1:0]            r_resp_q, r_resp_d;
  logic                  r_load;
  logic [7:0]            r_beat;
  logic [ADDR_WIDTH:0]   r_off;
  logic [ADDR_WIDTH-1:0] r_word;
  logic                  r_oob;

  w_state_t              w_state_q, w_state_d;
  logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
  logic [ADDR_WIDTH-1:0] w_addr_q, w_addr_d;
  logic [7:0]            w_len_q, w_len_d, w_cnt_q, w_cnt_d;
  logic                  w_fmt_err_q, w_fmt_err_d;
  logic [1:0]            w_err_q, w_err_d, w_err_acc, w_beat_err;
  logic [ADDR_WIDTH:0]   w_off;
  logic [ADDR_WIDTH-1:0] w_word;
  logic                  w_oob, w_end_len, mem_we;

  always_comb begin
    r_state_d   = r_state_q;
    r_id_d      = r_id_q;
    r_addr_d    = r_addr_q;
    r_len_d     = r_len_q;
    r_cnt_d     = r_cnt_q;
    r_wait_d    = r_wait_q;
    r_fmt_err_d = r_fmt_err_q;
    r_valid_d   = r_valid_q;
    r_last_d    = r_last_q;
    r_data_d    = r_data_q;
    r_resp_d    = r_resp_q;
    r_load      = 1'b0;
    s_axi_arready = ready_en_q && (r_state_q == R_IDLE);

    // Beat being prepared: 0 when leaving R_WAIT, otherwise the one after the current.
    r_beat = (r_state_q == R_WAIT) ? 8'd0 : r_cnt_q + 8'd1;
    r_off  = {1'b0, r_addr_q} - {1'b0, BASE_ADDR};
    r_word = (r_off[ADDR_WIDTH-1:0] >> 3) + {{(ADDR_WIDTH-8){1'b0}}, r_beat};
    r_oob  = r_off[ADDR_WIDTH] || (r_word >= DEPTH);

    unique case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && s_axi_arready) begin
          r_id_d      = s_axi_arid;
          r_addr_d    = s_axi_araddr;
          r_len_d     = s_axi_arlen;
          r_fmt_err_d = (s_axi_arburst != 2'b01) || (s_axi_arsize != 3'b011);
          r_cnt_d     = 8'd0;
          r_wait_d    = 8'd0;
          r_state_d   = R_WAIT;
        end
      end
      R_WAIT: begin
        if (r_wait_q == RL_LAST) begin
          r_load    = 1'b1;
          r_state_d = R_BURST;
        end else begin
          r_wait_d = r_wait_q + 8'd1;
        end
      end
      R_BURST: begin
        if (s_axi_rready) begin
          if (r_last_q) begin
            r_valid_d = 1'b0;
            r_last_d  = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d = r_beat;
            r_load  = 1'b1;
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    if (r_load) begin
      r_valid_d = 1'b1;
      r_last_d  = (r_beat == r_len_q);
      if (r_oob) begin
        r_resp_d = RESP_DECERR;
        r_data_d = '0;
      end else if (r_fmt_err_q) begin
        r_resp_d = RESP_SLVERR;
        r_data_d = '0;
      end else begin
        r_resp_d = RESP_OKAY;
        r_data_d = mem[r_word[IDX_W-1:0]];
      end
    end
  end

  always_comb begin
    w_state_d   = w_state_q;
    w_id_d      = w_id_q;
    w_addr_d    = w_addr_q;
    w_len_d     = w_len_q;
    w_cnt_d     = w_cnt_q;
    w_fmt_err_d = w_fmt_err_q;
    w_err_d     = w_err_q;
    w_err_acc   = w_err_q;
    mem_we      = 1'b0;
    s_axi_awready = ready_en_q && (w_state_q == W_IDLE);
    s_axi_wready  = (w_state_q == W_DATA);
    s_axi_acvalid = (w_state_q == W_SNOOP);
    s_axi_bvalid  = (w_state_q == W_RESP);

    w_off      = {1'b0, w_addr_q} - {1'b0, BASE_ADDR};
    w_word     = (w_off[ADDR_WIDTH-1:0] >> 3) + {{(ADDR_WIDTH-8){1'b0}}, w_cnt_q};
    w_oob      = w_off[ADDR_WIDTH] || (w_word >= DEPTH);
    w_beat_err = w_oob ? RESP_DECERR : (w_fmt_err_q ? RESP_SLVERR : RESP_OKAY);
    w_end_len  = (w_cnt_q == w_len_q);

    unique case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && s_axi_awready) begin
          w_id_d      = s_axi_awid;
          w_addr_d    = s_axi_awaddr;
          w_len_d     = s_axi_awlen;
          w_fmt_err_d = (s_axi_awburst != 2'b01) || (s_axi_awsize != 3'b011);
          w_cnt_d     = 8'd0;
          w_err_d     = RESP_OKAY;
          w_state_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          mem_we    = (w_beat_err == RESP_OKAY);
          w_err_acc = worse(w_err_q, w_beat_err);
          // A burst ending early on wlast, or running past len, is malformed.
          if (s_axi_wlast != w_end_len) w_err_acc = worse(w_err_acc, RESP_SLVERR);
          w_err_d = w_err_acc;
          if (s_axi_wlast || w_end_len) begin
            w_state_d = (w_err_acc == RESP_OKAY) ? W_SNOOP : W_RESP;
          end else begin
            w_cnt_d = w_cnt_q + 8'd1;
          end
        end
      end
      W_SNOOP: if (s_axi_acready) w_state_d = W_RESP;
      W_RESP:  if (s_axi_bready)  w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
  end

  assign s_axi_rid     = r_id_q;
  assign s_axi_rdata   = r_data_q;
  assign s_axi_rresp   = r_resp_q;
  assign s_axi_rlast   = r_last_q;
  assign s_axi_rvalid  = r_valid_q;
  assign s_axi_bid     = w_id_q;
  assign s_axi_bresp   = w_err_q;
  assign s_axi_acaddr  = {w_addr_q[ADDR_WIDTH-1:6], 6'b0};
  assign s_axi_acsnoop = s_axi_acvalid ? 4'b1101 : 4'b0000;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en_q  <= 1'b0;
      r_state_q   <= R_IDLE;
      r_id_q      <= '0;
      r_addr_q    <= '0;
      r_len_q     <= '0;
      r_cnt_q     <= '0;
      r_wait_q    <= '0;
      r_fmt_err_q <= 1'b0;
      r_valid_q   <= 1'b0;
      r_last_q    <= 1'b0;
      r_data_q    <= '0;
      r_resp_q    <= '0;
      w_state_q   <= W_IDLE;
      w_id_q      <= '0;
      w_addr_q    <= '0;
      w_len_q     <= '0;
      w_cnt_q     <= '0;
      w_fmt_err_q <= 1'b0;
      w_err_q     <= '0;
    end else begin
      ready_en_q  <= 1'b1;
      r_state_q   <= r_state_d;
      r_id_q      <= r_id_d;
      r_addr_q    <= r_addr_d;
      r_len_q     <= r_len_d;
      r_cnt_q     <= r_cnt_d;
      r_wait_q    <= r_wait_d;
      r_fmt_err_q <= r_fmt_err_d;
      r_valid_q   <= r_valid_d;
      r_last_q    <= r_last_d;
      r_data_q    <= r_data_d;
      r_resp_q    <= r_resp_d;
      w_state_q   <= w_state_d;
      w_id_q      <= w_id_d;
      w_addr_q    <= w_addr_d;
      w_len_q     <= w_len_d;
      w_cnt_q     <= w_cnt_d;
      w_fmt_err_q <= w_fmt_err_d;
      w_err_q     <= w_err_d;
    end
  end

  // Array contents survive reset. A read loading the same word in this cycle
  // sees the old contents because the write lands at the edge.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++) begin
        if (s_axi_wstrb[b]) mem[w_word[IDX_W-1:0]][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

endmodule
